// File: rtl/seq_mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state encoding
// and the iteration-counter width derived from the operand width.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must hold WIDTH-1; the extra bit keeps power-of-two widths safe.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, unsigned or
// two's-complement operands chosen per transaction, valid/ready on both sides.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t               state_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [CW-1:0]        count_reg;
    logic                 sign_reg;
    logic [2*WIDTH-1:0]   p_reg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc_next;

    // Magnitude of the most negative value wraps to itself, which is correct
    // when read back as an unsigned WIDTH-bit number.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // The multiplicand register is pre-shifted each iteration, so the current
    // partial product is simply gated by the multiplier LSB.
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            sign_reg   <= 1'b0;
            p_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_reg <= b_mag;
                        sign_reg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        state_reg  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CW'(1);
                    if (count_reg == LAST_ITER) begin
                        p_reg     <= sign_reg ? (~acc_next + 1'b1) : acc_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign p         = p_reg;

endmodule
